// File: rtl/target_tracker_if.sv
// Pixel-stream and frame-result bundle between a VGA pixel source and target_tracker.
// master drives the pixel stream and reads results; slave is the tracker side.
interface target_tracker_if;
    logic       DE;
    logic [9:0] x_pixel;
    logic [9:0] y_pixel;
    logic       is_target_color;

    logic [9:0]  obj_x_min;
    logic [9:0]  obj_x_max;
    logic [9:0]  obj_y_min;
    logic [9:0]  obj_y_max;
    logic [9:0]  obj_cx;
    logic [9:0]  obj_cy;
    logic [18:0] obj_count;
    logic        obj_valid;
    logic        frame_done;

    modport master (
        output DE, x_pixel, y_pixel, is_target_color,
        input  obj_x_min, obj_x_max, obj_y_min, obj_y_max,
        input  obj_cx, obj_cy, obj_count, obj_valid, frame_done
    );

    modport slave (
        input  DE, x_pixel, y_pixel, is_target_color,
        output obj_x_min, obj_x_max, obj_y_min, obj_y_max,
        output obj_cx, obj_cy, obj_count, obj_valid, frame_done
    );
endinterface

// File: rtl/target_tracker.sv
// Per-frame bounding box, centre and pixel count of colour-matched runs in a VGA stream.
// Results of each frame are published at the next frame's first active pixel (0,0).
module target_tracker #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int RUN_LEN    = 4,
    parameter int MIN_PIXELS = 64
) (
    input  logic             clk_25MHz,
    input  logic             reset,
    target_tracker_if.slave  px
);

    typedef enum logic {IDLE, TRACK} state_t;

    localparam logic [10:0] H_LIMIT   = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIMIT   = 11'(V_ACTIVE);
    localparam logic [9:0]  X_EMPTY   = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_EMPTY   = 10'(V_ACTIVE - 1);
    localparam logic [3:0]  RUN_MAX   = 4'(RUN_LEN);
    localparam logic [9:0]  RUN_BACK  = 10'(RUN_LEN - 1);
    localparam logic [4:0]  RUN_ADD   = 5'(RUN_LEN);
    localparam logic [19:0] MIN_COUNT = 20'(MIN_PIXELS);
    localparam logic [18:0] COUNT_MAX = '1;

    state_t state, state_next;

    logic        active, boundary, report, accumulate;
    logic        qualify;
    logic [4:0]  add;
    logic [9:0]  qual_x_lo;
    logic [3:0]  run_cnt, run_base, run_next;
    logic [19:0] count_sum;

    logic [9:0]  acc_x_min, acc_x_max, acc_y_min, acc_y_max;
    logic [18:0] acc_count;
    logic [9:0]  base_x_min, base_x_max, base_y_min, base_y_max;
    logic [18:0] base_count;
    logic [9:0]  next_x_min, next_x_max, next_y_min, next_y_max;
    logic [18:0] next_count;
    logic [10:0] cx_sum, cy_sum;

    always_ff @(posedge clk_25MHz or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch can be inferred.
        state_next = state;
        report     = 1'b0;
        boundary   = 1'b0;
        active     = px.DE && ({1'b0, px.x_pixel} < H_LIMIT) && ({1'b0, px.y_pixel} < V_LIMIT);
        boundary   = active && (px.x_pixel == 10'd0) && (px.y_pixel == 10'd0);
        case (state)
            IDLE:  if (boundary) state_next = TRACK;
            TRACK: report = boundary;
            default: state_next = IDLE;
        endcase
    end

    // A pixel at x=0 never extends a run from the previous line.
    always_comb begin
        run_base  = (px.x_pixel == 10'd0) ? 4'd0 : run_cnt;
        run_next  = 4'd0;
        qualify   = 1'b0;
        add       = 5'd0;
        qual_x_lo = px.x_pixel;
        if (active && px.is_target_color) begin
            if (run_base >= RUN_MAX) begin
                run_next = RUN_MAX;
                qualify  = 1'b1;
                add      = 5'd1;
            end else begin
                run_next = run_base + 4'd1;
                if (run_next == RUN_MAX) begin
                    qualify   = 1'b1;
                    add       = RUN_ADD;
                    qual_x_lo = px.x_pixel - RUN_BACK;
                end
            end
        end
    end

    always_comb begin
        accumulate = (state == TRACK) || boundary;
        if (boundary) begin
            base_x_min = X_EMPTY;
            base_x_max = 10'd0;
            base_y_min = Y_EMPTY;
            base_y_max = 10'd0;
            base_count = 19'd0;
        end else begin
            base_x_min = acc_x_min;
            base_x_max = acc_x_max;
            base_y_min = acc_y_min;
            base_y_max = acc_y_max;
            base_count = acc_count;
        end
        count_sum  = {1'b0, base_count} + 20'(add);
        next_x_min = base_x_min;
        next_x_max = base_x_max;
        next_y_min = base_y_min;
        next_y_max = base_y_max;
        next_count = base_count;
        if (accumulate && qualify) begin
            next_x_min = (qual_x_lo   < base_x_min) ? qual_x_lo   : base_x_min;
            next_x_max = (px.x_pixel  > base_x_max) ? px.x_pixel  : base_x_max;
            next_y_min = (px.y_pixel  < base_y_min) ? px.y_pixel  : base_y_min;
            next_y_max = (px.y_pixel  > base_y_max) ? px.y_pixel  : base_y_max;
            next_count = count_sum[19] ? COUNT_MAX : count_sum[18:0];
        end
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            run_cnt   <= 4'd0;
            acc_x_min <= X_EMPTY;
            acc_x_max <= 10'd0;
            acc_y_min <= Y_EMPTY;
            acc_y_max <= 10'd0;
            acc_count <= 19'd0;
        end else begin
            run_cnt   <= run_next;
            acc_x_min <= next_x_min;
            acc_x_max <= next_x_max;
            acc_y_min <= next_y_min;
            acc_y_max <= next_y_max;
            acc_count <= next_count;
        end
    end

    // An empty frame still holds the empty box in the accumulators, so it publishes as-is.
    assign cx_sum = {1'b0, acc_x_min} + {1'b0, acc_x_max};
    assign cy_sum = {1'b0, acc_y_min} + {1'b0, acc_y_max};

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            px.obj_x_min  <= 10'd0;
            px.obj_x_max  <= 10'd0;
            px.obj_y_min  <= 10'd0;
            px.obj_y_max  <= 10'd0;
            px.obj_cx     <= 10'd0;
            px.obj_cy     <= 10'd0;
            px.obj_count  <= 19'd0;
            px.obj_valid  <= 1'b0;
            px.frame_done <= 1'b0;
        end else begin
            px.frame_done <= report;
            if (report) begin
                px.obj_x_min <= acc_x_min;
                px.obj_x_max <= acc_x_max;
                px.obj_y_min <= acc_y_min;
                px.obj_y_max <= acc_y_max;
                px.obj_cx    <= cx_sum[10:1];
                px.obj_cy    <= cy_sum[10:1];
                px.obj_count <= acc_count;
                px.obj_valid <= ({1'b0, acc_count} >= MIN_COUNT);
            end
        end
    end

endmodule

// File: tb/tb_target_tracker.sv
// Directed bench for target_tracker: sparse pixel sequences per frame, results checked at
// each (0,0) boundary against hand-computed boxes, centres and counts.
module tb_target_tracker;

    logic clk_25MHz = 1'b0;
    logic reset     = 1'b1;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    target_tracker_if tif ();

    target_tracker #(
        .H_ACTIVE   (640),
        .V_ACTIVE   (480),
        .RUN_LEN    (4),
        .MIN_PIXELS (64)
    ) dut (
        .clk_25MHz (clk_25MHz),
        .reset     (reset),
        .px        (tif)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    // {frame_done, obj_valid, obj_count, x_min, x_max, y_min, y_max, cx, cy}
    function automatic logic [80:0] observed();
        return {tif.frame_done, tif.obj_valid, tif.obj_count, tif.obj_x_min, tif.obj_x_max,
                tif.obj_y_min, tif.obj_y_max, tif.obj_cx, tif.obj_cy};
    endfunction

    function automatic logic [80:0] pack(input logic fd, input logic valid, input logic [18:0] cnt,
                                         input logic [9:0] xmin, input logic [9:0] xmax,
                                         input logic [9:0] ymin, input logic [9:0] ymax,
                                         input logic [9:0] cx, input logic [9:0] cy);
        return {fd, valid, cnt, xmin, xmax, ymin, ymax, cx, cy};
    endfunction

    task automatic drive(input logic de, input int x, input int y, input logic t);
        tif.DE              = de;
        tif.x_pixel         = 10'(x);
        tif.y_pixel         = 10'(y);
        tif.is_target_color = t;
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic segment(input int y, input int x0, input int x1, input int t0, input int t1);
        for (int x = x0; x <= x1; x++) drive(1'b1, x, y, (x >= t0) && (x <= t1));
    endtask

    task automatic test_reset();
        logic [80:0] got;
        reset = 1'b1;
        drive(1'b0, 0, 0, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        got = observed();
        n_compared++;
        if (got !== 81'd0) begin
            n_mismatched++;
            $display("FAIL reset_state: got %h required %h", got, 81'd0);
        end
        reset = 1'b0;
        drive(1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_first_frame();
        logic [80:0] got, exp;
        drive(1'b1, 0, 0, 1'b0);
        got = observed();
        n_compared++;
        if (got !== 81'd0) begin
            n_mismatched++;
            $display("FAIL first_boundary_silent: got %h required %h", got, 81'd0);
        end
        for (int y = 50; y <= 57; y++) segment(y, 98, 109, 100, 107);
        drive(1'b1, 0, 0, 1'b0);
        got = observed();
        exp = pack(1'b1, 1'b1, 19'd64, 10'd100, 10'd107, 10'd50, 10'd57, 10'd103, 10'd53);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL block_8x8: got %h required %h", got, exp);
        end
        drive(1'b0, 0, 0, 1'b0);
        exp[80] = 1'b0;
        got = observed();
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL frame_done_single_pulse: got %h required %h", got, exp);
        end
        repeat (5) drive(1'b0, 0, 0, 1'b0);
        got = observed();
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL outputs_hold: got %h required %h", got, exp);
        end
    endtask

    task automatic test_short_runs();
        logic [80:0] got, exp;
        segment(5, 10, 14, 11, 13);
        segment(100, 600, 604, 601, 603);
        segment(300, 0, 5, 0, 2);
        segment(479, 636, 639, 637, 639);
        drive(1'b1, 0, 0, 1'b0);
        got = observed();
        exp = pack(1'b1, 1'b0, 19'd0, 10'd639, 10'd0, 10'd479, 10'd0, 10'd319, 10'd239);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL short_runs_empty: got %h required %h", got, exp);
        end
    endtask

    task automatic test_line_wrap();
        logic [80:0] got, exp;
        segment(10, 630, 639, 636, 639);
        segment(11, 0, 3, 0, 1);
        drive(1'b1, 0, 0, 1'b0);
        got = observed();
        exp = pack(1'b1, 1'b0, 19'd4, 10'd636, 10'd639, 10'd10, 10'd10, 10'd637, 10'd10);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL line_wrap: got %h required %h", got, exp);
        end
    endtask

    // Leaves the frame open; test_origin closes it.
    task automatic test_out_of_range();
        segment(20, 8, 15, 10, 13);
        repeat (10) drive(1'b1, 700, 20, 1'b1);
        repeat (5) drive(1'b1, 5, 500, 1'b1);
        segment(30, 20, 22, 20, 22);
        drive(1'b1, 700, 30, 1'b1);
        segment(30, 23, 25, 23, 24);
        segment(40, 10, 11, 10, 11);
        drive(1'b0, 12, 40, 1'b1);
        segment(40, 12, 14, 12, 13);
    endtask

    task automatic test_origin();
        logic [80:0] got, exp;
        drive(1'b1, 0, 0, 1'b1);
        got = observed();
        exp = pack(1'b1, 1'b0, 19'd4, 10'd10, 10'd13, 10'd20, 10'd20, 10'd11, 10'd20);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL out_of_range_ignored: got %h required %h", got, exp);
        end
        segment(0, 1, 4, 1, 3);
        drive(1'b1, 0, 0, 1'b0);
        got = observed();
        exp = pack(1'b1, 1'b0, 19'd4, 10'd0, 10'd3, 10'd0, 10'd0, 10'd1, 10'd0);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL origin_pixel_new_frame: got %h required %h", got, exp);
        end
    endtask

    task automatic test_mid_reset();
        logic [80:0] got, exp;
        segment(100, 48, 56, 50, 55);
        segment(200, 0, 3, 0, 3);
        reset = 1'b1;
        #1;
        got = observed();
        n_compared++;
        if (got !== 81'd0) begin
            n_mismatched++;
            $display("FAIL async_reset_clears: got %h required %h", got, 81'd0);
        end
        drive(1'b1, 4, 200, 1'b1);
        reset = 1'b0;
        segment(250, 10, 20, 10, 20);
        drive(1'b1, 0, 0, 1'b0);
        got = observed();
        n_compared++;
        if (got !== 81'd0) begin
            n_mismatched++;
            $display("FAIL no_done_after_reset: got %h required %h", got, 81'd0);
        end
        segment(200, 298, 305, 300, 303);
        segment(201, 298, 305, 300, 303);
        drive(1'b1, 0, 0, 1'b0);
        got = observed();
        exp = pack(1'b1, 1'b0, 19'd8, 10'd300, 10'd303, 10'd200, 10'd201, 10'd301, 10'd200);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL frame_after_reset: got %h required %h", got, exp);
        end
        drive(1'b0, 0, 0, 1'b0);
        exp[80] = 1'b0;
        got = observed();
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL done_drop_after_reset: got %h required %h", got, exp);
        end
    endtask

    initial begin
        tif.DE              = 1'b0;
        tif.x_pixel         = 10'd0;
        tif.y_pixel         = 10'd0;
        tif.is_target_color = 1'b0;
        test_reset();
        test_first_frame();
        test_short_runs();
        test_line_wrap();
        test_out_of_range();
        test_origin();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
